ddi_multi_phase_ctrl: RTL and testbench
=======================================

// Module: ddi_multi_phase_ctrl
// PURPOSE
//  Parametrised next-generation DDI signal sequencer. Runs NUM_PHASES normal phases round-robin
//  and NUM_PRIO priority channels. Dwell timing is internal: per-state tick counters replace the
//  external timing_done handshake. Sits between the sync controller (priority requests, tick
//  timebase) and the lamp drivers (one-hot green/yellow masks, flashing-red).
// PARAMETERS
//  NUM_PHASES    2   normal phases served round-robin (>=1)
//  NUM_PRIO      2   priority channels, e.g. east/west (>=1)
//  CNT_W         8   dwell counter width; every *_TICKS value must be < 2**CNT_W
//  GREEN_TICKS   30  green dwell of a normal phase, in ticks (>=1)
//  PRIO_TICKS    15  green dwell of a priority channel, in ticks (>=1)
//  YELLOW_TICKS  4   yellow dwell, all channels (>=1)
//  ALLRED_TICKS  2   all-red clearance dwell (>=1)
//  FLASH_TICKS   1   flashing-red half-period in maintenance (>=1)
// PORTS  (NCH = NUM_PHASES+NUM_PRIO, IDX_W = max(1,$clog2(NCH)))
//  clk          in   1      system clock
//  rst          in   1      synchronous, active-high reset
//  tick         in   1      timebase enable; counters advance only when tick=1
//  prio_req     in   NUM_PRIO   level/pulse priority requests from the sync controller
//  maintenance  in   1      level; high = flashing-red maintenance mode
//  state        out  2      ALL_RED=0, GREEN=1, YELLOW=2, MAINT=3
//  active_idx   out  IDX_W  channel being served: 0..NUM_PHASES-1 phases, then priority channels
//  green_mask   out  NCH    one-hot at active_idx in GREEN, else 0
//  yellow_mask  out  NCH    one-hot at active_idx in YELLOW, else 0
//  flash_red    out  1      toggling lamp enable in MAINT, 0 elsewhere
//  prio_ack     out  NUM_PRIO  1-cycle pulse, bit k, on the cycle GREEN for priority k is entered
//  cycle_done   out  1      1-cycle pulse when YELLOW of phase NUM_PHASES-1 expires
// BEHAVIOUR
//  - All outputs registered. Reset (rst, highest priority): state=ALL_RED,
//    timer=ALLRED_TICKS-1, active_idx=0, phase_ptr=0, pending=0, masks/flash/ack/done=0.
//  - Dwell: on state entry, timer loads DUR-1. Expiry = tick && timer==0; otherwise tick
//    decrements. DUR=1 leaves on the first tick after entry. No change while tick=0.
//  - pending[k] is sticky: pending <= (pending & ~grant) | prio_req. A request in the grant
//    cycle remains pending.
//  - ALL_RED expiry: if pending!=0, serve the lowest set k: GREEN, active_idx=NUM_PHASES+k,
//    load PRIO_TICKS, prio_ack[k]=1. Else serve phase_ptr: GREEN, active_idx=phase_ptr,
//    load GREEN_TICKS.
//  - GREEN expiry -> YELLOW (YELLOW_TICKS), same active_idx.
//  - YELLOW expiry -> ALL_RED (ALLRED_TICKS). If a phase was served, phase_ptr
//    <= (phase_ptr==NUM_PHASES-1) ? 0 : phase_ptr+1 and cycle_done pulses on wrap.
//    A priority channel does not move phase_ptr.
//  - Maintenance: maintenance=1 at any edge (rst=0) -> MAINT next cycle, from any state.
//    Masks cleared; flash_red=1; timer=FLASH_TICKS-1; flash_red toggles on each expiry.
//  - MAINT exit: maintenance=0 -> ALL_RED with full ALLRED_TICKS clearance, flash_red=0.
//    phase_ptr and pending are held; no green without clearance.
//  - Simultaneous maintenance and expiry: maintenance wins; no ack/cycle_done pulse.
//  - Never two bits set across green_mask|yellow_mask. Unused state codes recover to ALL_RED.
// STRUCTURE
//  - ddi_defs.vh: state codes (ST_ALL_RED..ST_MAINT) and the NCH/IDX_W helper macros.
//  - Sub-module ddi_dwell_timer (CNT_W): load value, load strobe, tick in, expired out.
//    Instantiated once and shared by all states.
//  - Top: next-state case, pending/priority encoder, phase_ptr, output registers.
// TESTING  (GREEN=3, PRIO=2, YELLOW=2, ALLRED=1, FLASH=2, tick=1 every cycle unless stated)
//  1. Release rst, no requests -> phases 0,1,0 in order. Each has 3 green, 2 yellow and
//     1 all-red cycles. cycle_done pulses once per 2-phase round.
//  2. prio_req=2'b11 for 1 cycle during phase 0 green -> after the clearance, ch 2
//     (prio_ack=01) then ch 3 (prio_ack=10), then phase 1 resumes.
//  3. tick=1 only every 3rd cycle -> all dwells stretch x3; state is frozen on non-tick cycles.
//  4. maintenance=1 mid-GREEN -> MAINT next cycle, masks=0, flash_red toggles every 2 cycles.
//     Drop maintenance -> 1 ALL_RED cycle, then the held phase_ptr is served.
//  5. rst=1 in YELLOW with pending=01 -> ALL_RED, pending=0, phase_ptr=0, all outputs reset.
//  6. prio_req[0] held high through its grant -> ch 2 is served again at the next ALL_RED.
//     Phases are starved while it is held (documented behaviour).

Source files
------------

// File: rtl/ddi_multi_phase_ctrl_pkg.sv
// Shared definitions for the DDI multi-phase signal sequencer: state
// encoding and the index-width helper used to size channel ports.
package ddi_multi_phase_ctrl_pkg;

  // Lamp-sequencer states; the numeric codes are visible on the state port.
  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_MAINT   = 2'd3
  } ddi_state_e;

  // Width of an index able to address n items, never less than one bit.
  function automatic int idx_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/ddi_multi_phase_ctrl_dwell_timer.sv
// Shared dwell timer for the sequencer. A load strobe reloads the count
// (DUR-1); each tick decrements it; expiry is a tick seen while the count
// is already zero, so a load value of zero expires on the first tick.
module ddi_dwell_timer #(
  parameter int CNT_W   = 8,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] timer_r;

  // Expiry is qualified by tick so nothing happens on non-tick cycles.
  assign expired = tick & (timer_r == {CNT_W{1'b0}});

  // Count register: load wins, otherwise step down on ticks, hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r <= CNT_W'(RST_VAL);
    end else if (load) begin
      timer_r <= load_val;
    end else if (tick && (timer_r != {CNT_W{1'b0}})) begin
      timer_r <= timer_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      timer_r <= timer_r;
    end
  end

endmodule

// File: rtl/ddi_multi_phase_ctrl.sv
// DDI multi-phase signal sequencer. Serves NUM_PHASES normal phases
// round-robin and NUM_PRIO priority channels through GREEN -> YELLOW ->
// ALL_RED, with internally timed dwells and a flashing-red maintenance mode.
// Channel indices: 0..NUM_PHASES-1 are phases, then the priority channels.
module ddi_multi_phase_ctrl
  import ddi_multi_phase_ctrl_pkg::*;
#(
  parameter int  NUM_PHASES   = 2,
  parameter int  NUM_PRIO     = 2,
  parameter int  CNT_W        = 8,
  parameter int  GREEN_TICKS  = 30,
  parameter int  PRIO_TICKS   = 15,
  parameter int  YELLOW_TICKS = 4,
  parameter int  ALLRED_TICKS = 2,
  parameter int  FLASH_TICKS  = 1,
  localparam int NCH          = NUM_PHASES + NUM_PRIO,
  localparam int IDX_W        = idx_width(NCH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [NUM_PRIO-1:0] prio_req,
  input  logic                maintenance,
  output logic [1:0]          state,
  output logic [IDX_W-1:0]    active_idx,
  output logic [NCH-1:0]      green_mask,
  output logic [NCH-1:0]      yellow_mask,
  output logic                flash_red,
  output logic [NUM_PRIO-1:0] prio_ack,
  output logic                cycle_done
);

  localparam int PTR_W = idx_width(NUM_PHASES);
  localparam int SEL_W = idx_width(NUM_PRIO);

  // Timer reload values are DUR-1 so a dwell of N ticks spans N tick edges.
  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] PRIO_LOAD   = CNT_W'(PRIO_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD  = CNT_W'(FLASH_TICKS - 1);

  localparam logic [IDX_W-1:0] FIRST_PRIO_IDX = IDX_W'(NUM_PHASES);
  localparam logic [PTR_W-1:0] LAST_PHASE     = PTR_W'(NUM_PHASES - 1);

  // Registered state and outputs.
  ddi_state_e          state_r;
  logic [IDX_W-1:0]    active_idx_r;
  logic [PTR_W-1:0]    phase_ptr_r;
  logic [NUM_PRIO-1:0] pending_r;
  logic [NCH-1:0]      green_mask_r;
  logic [NCH-1:0]      yellow_mask_r;
  logic                flash_red_r;
  logic [NUM_PRIO-1:0] prio_ack_r;
  logic                cycle_done_r;

  // Next-state values.
  ddi_state_e          state_s;
  logic [IDX_W-1:0]    active_idx_s;
  logic [PTR_W-1:0]    phase_ptr_s;
  logic [NUM_PRIO-1:0] pending_s;
  logic [NCH-1:0]      green_mask_s;
  logic [NCH-1:0]      yellow_mask_s;
  logic                flash_red_s;
  logic [NUM_PRIO-1:0] prio_ack_s;
  logic                cycle_done_s;

  // Priority selection and timer control.
  logic [SEL_W-1:0]    prio_sel_s;
  logic [NUM_PRIO-1:0] grant_s;
  logic                load_s;
  logic [CNT_W-1:0]    load_val_s;
  logic                expired_s;
  logic [NCH-1:0]      active_onehot_s;

  // Lowest-numbered set bit wins, so channel 0 has the highest priority.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_PRIO-1:0] v);
    logic [SEL_W-1:0] sel;
    sel = {SEL_W{1'b0}};
    for (int k = NUM_PRIO - 1; k >= 0; k--) begin
      if (v[k]) begin
        sel = SEL_W'(k);
      end
    end
    return sel;
  endfunction

  // One timer serves every state; it is reloaded on each state entry.
  ddi_dwell_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_TICKS - 1)
  ) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (load_s),
    .load_val (load_val_s),
    .expired  (expired_s)
  );

  // Priority encoder over the sticky pending requests.
  always_comb begin
    prio_sel_s = lowest_set(pending_r);
  end

  // Next-state, timer reload and pulse generation; maintenance overrides all.
  always_comb begin
    state_s      = state_r;
    active_idx_s = active_idx_r;
    phase_ptr_s  = phase_ptr_r;
    flash_red_s  = 1'b0;
    prio_ack_s   = {NUM_PRIO{1'b0}};
    cycle_done_s = 1'b0;
    grant_s      = {NUM_PRIO{1'b0}};
    load_s       = 1'b0;
    load_val_s   = ALLRED_LOAD;

    if (maintenance) begin
      state_s = ST_MAINT;
      if (state_r != ST_MAINT) begin
        load_s      = 1'b1;
        load_val_s  = FLASH_LOAD;
        flash_red_s = 1'b1;
      end else if (expired_s) begin
        load_s      = 1'b1;
        load_val_s  = FLASH_LOAD;
        flash_red_s = ~flash_red_r;
      end else begin
        flash_red_s = flash_red_r;
      end
    end else begin
      case (state_r)
        ST_ALL_RED: begin
          if (expired_s) begin
            state_s = ST_GREEN;
            load_s  = 1'b1;
            if (pending_r != {NUM_PRIO{1'b0}}) begin
              active_idx_s = FIRST_PRIO_IDX + IDX_W'(prio_sel_s);
              load_val_s   = PRIO_LOAD;
              grant_s      = NUM_PRIO'(1'b1) << prio_sel_s;
              prio_ack_s   = NUM_PRIO'(1'b1) << prio_sel_s;
            end else begin
              active_idx_s = IDX_W'(phase_ptr_r);
              load_val_s   = GREEN_LOAD;
            end
          end else begin
            state_s = ST_ALL_RED;
          end
        end
        ST_GREEN: begin
          if (expired_s) begin
            state_s    = ST_YELLOW;
            load_s     = 1'b1;
            load_val_s = YELLOW_LOAD;
          end else begin
            state_s = ST_GREEN;
          end
        end
        ST_YELLOW: begin
          if (expired_s) begin
            state_s    = ST_ALL_RED;
            load_s     = 1'b1;
            load_val_s = ALLRED_LOAD;
            // Only a normal phase advances the round-robin pointer.
            if (active_idx_r < FIRST_PRIO_IDX) begin
              if (phase_ptr_r == LAST_PHASE) begin
                phase_ptr_s  = {PTR_W{1'b0}};
                cycle_done_s = 1'b1;
              end else begin
                phase_ptr_s = phase_ptr_r + PTR_W'(1'b1);
              end
            end else begin
              phase_ptr_s = phase_ptr_r;
            end
          end else begin
            state_s = ST_YELLOW;
          end
        end
        ST_MAINT: begin
          // Leaving maintenance always goes through a full clearance.
          state_s    = ST_ALL_RED;
          load_s     = 1'b1;
          load_val_s = ALLRED_LOAD;
        end
        default: begin
          state_s      = ST_ALL_RED;
          active_idx_s = {IDX_W{1'b0}};
          load_s       = 1'b1;
          load_val_s   = ALLRED_LOAD;
        end
      endcase
    end
  end

  // Sticky requests: a grant clears its bit unless re-requested that cycle.
  always_comb begin
    pending_s = (pending_r & ~grant_s) | prio_req;
  end

  // Lamp masks follow the next state so they stay aligned with state.
  always_comb begin
    active_onehot_s = NCH'(1'b1) << active_idx_s;
    green_mask_s    = (state_s == ST_GREEN)  ? active_onehot_s : {NCH{1'b0}};
    yellow_mask_s   = (state_s == ST_YELLOW) ? active_onehot_s : {NCH{1'b0}};
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_ALL_RED;
      active_idx_r  <= {IDX_W{1'b0}};
      phase_ptr_r   <= {PTR_W{1'b0}};
      pending_r     <= {NUM_PRIO{1'b0}};
      green_mask_r  <= {NCH{1'b0}};
      yellow_mask_r <= {NCH{1'b0}};
      flash_red_r   <= 1'b0;
      prio_ack_r    <= {NUM_PRIO{1'b0}};
      cycle_done_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      active_idx_r  <= active_idx_s;
      phase_ptr_r   <= phase_ptr_s;
      pending_r     <= pending_s;
      green_mask_r  <= green_mask_s;
      yellow_mask_r <= yellow_mask_s;
      flash_red_r   <= flash_red_s;
      prio_ack_r    <= prio_ack_s;
      cycle_done_r  <= cycle_done_s;
    end
  end

  assign state       = state_r;
  assign active_idx  = active_idx_r;
  assign green_mask  = green_mask_r;
  assign yellow_mask = yellow_mask_r;
  assign flash_red   = flash_red_r;
  assign prio_ack    = prio_ack_r;
  assign cycle_done  = cycle_done_r;

endmodule

// File: tb/tb_ddi_multi_phase_ctrl.sv
// Scoreboard bench for ddi_multi_phase_ctrl with GREEN=3, PRIO=2, YELLOW=2,
// ALLRED=1, FLASH=2. Stimulus is a per-cycle schedule; expected output
// events (state/index/flash changes or pulses) with the cycle gap since the
// previous event are queued, and a monitor pops one per observed event.
module tb_ddi_multi_phase_ctrl;

  localparam logic [1:0] AR = 2'd0;
  localparam logic [1:0] G  = 2'd1;
  localparam logic [1:0] Y  = 2'd2;
  localparam logic [1:0] M  = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic [1:0] prio_req = 2'b00;
  logic       maintenance = 1'b0;
  logic [1:0] state;
  logic [1:0] active_idx;
  logic [3:0] green_mask;
  logic [3:0] yellow_mask;
  logic       flash_red;
  logic [1:0] prio_ack;
  logic       cycle_done;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  typedef struct {
    logic [1:0] st;
    logic [1:0] idx;
    logic       fl;
    logic [1:0] ack;
    logic       done;
    int         gap;   // 0 = gap not checked
  } ev_t;

  ev_t exp_q[$];

  ddi_multi_phase_ctrl #(
    .NUM_PHASES   (2),
    .NUM_PRIO     (2),
    .CNT_W        (8),
    .GREEN_TICKS  (3),
    .PRIO_TICKS   (2),
    .YELLOW_TICKS (2),
    .ALLRED_TICKS (1),
    .FLASH_TICKS  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .prio_req    (prio_req),
    .maintenance (maintenance),
    .state       (state),
    .active_idx  (active_idx),
    .green_mask  (green_mask),
    .yellow_mask (yellow_mask),
    .flash_red   (flash_red),
    .prio_ack    (prio_ack),
    .cycle_done  (cycle_done)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  task automatic push_ev(input logic [1:0] st, input logic [1:0] idx, input logic fl,
                         input logic [1:0] ack, input logic done, input int gap);
    ev_t e;
    e.st = st; e.idx = idx; e.fl = fl; e.ack = ack; e.done = done; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: detect output events at negedge and compare against the queue.
  initial begin : monitor
    logic [1:0] p_st;
    logic [1:0] p_idx;
    logic       p_fl;
    int         gap;
    ev_t        e;
    logic [3:0] exp_g;
    logic [3:0] exp_y;
    p_st = AR; p_idx = 2'd0; p_fl = 1'b0; gap = 0;
    wait (armed);
    forever begin
      @(negedge clk);
      gap++;
      check("mask_exclusive", {31'd0, $countones(green_mask | yellow_mask) <= 1}, 32'd1);
      if (state !== p_st || active_idx !== p_idx || flash_red !== p_fl ||
          prio_ack !== 2'b00 || cycle_done !== 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got state=%0d idx=%0d expected no event (t=%0t)",
                   state, active_idx, $time);
        end else begin
          e = exp_q.pop_front();
          exp_g = (e.st == G) ? (4'b0001 << e.idx) : 4'b0000;
          exp_y = (e.st == Y) ? (4'b0001 << e.idx) : 4'b0000;
          check("state",       {30'd0, state},       {30'd0, e.st});
          check("active_idx",  {30'd0, active_idx},  {30'd0, e.idx});
          check("green_mask",  {28'd0, green_mask},  {28'd0, exp_g});
          check("yellow_mask", {28'd0, yellow_mask}, {28'd0, exp_y});
          check("flash_red",   {31'd0, flash_red},   {31'd0, e.fl});
          check("prio_ack",    {30'd0, prio_ack},    {30'd0, e.ack});
          check("cycle_done",  {31'd0, cycle_done},  {31'd0, e.done});
          if (e.gap != 0) begin
            check("dwell_gap", gap, e.gap);
          end
        end
        p_st = state; p_idx = active_idx; p_fl = flash_red; gap = 0;
      end
    end
  end

  // Stimulus: reset check, expected event table, then the cycle schedule.
  initial begin : stimulus
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state",       {30'd0, state},       32'd0);
    check("rst_active_idx",  {30'd0, active_idx},  32'd0);
    check("rst_green_mask",  {28'd0, green_mask},  32'd0);
    check("rst_yellow_mask", {28'd0, yellow_mask}, 32'd0);
    check("rst_flash_red",   {31'd0, flash_red},   32'd0);
    check("rst_prio_ack",    {30'd0, prio_ack},    32'd0);
    check("rst_cycle_done",  {31'd0, cycle_done},  32'd0);

    // Phases 0,1,0 round-robin; cycle_done on the wrap.
    push_ev(G,  2'd0, 1'b0, 2'b00, 1'b0, 0);   // c1
    push_ev(Y,  2'd0, 1'b0, 2'b00, 1'b0, 3);   // c4
    push_ev(AR, 2'd0, 1'b0, 2'b00, 1'b0, 2);   // c6
    push_ev(G,  2'd1, 1'b0, 2'b00, 1'b0, 1);   // c7
    push_ev(Y,  2'd1, 1'b0, 2'b00, 1'b0, 3);   // c10
    push_ev(AR, 2'd1, 1'b0, 2'b00, 1'b1, 2);   // c12
    push_ev(G,  2'd0, 1'b0, 2'b00, 1'b0, 1);   // c13
    // prio_req=11 at c14: ch2 then ch3, then phase 1.
    push_ev(Y,  2'd0, 1'b0, 2'b00, 1'b0, 3);   // c16
    push_ev(AR, 2'd0, 1'b0, 2'b00, 1'b0, 2);   // c18
    push_ev(G,  2'd2, 1'b0, 2'b01, 1'b0, 1);   // c19
    push_ev(Y,  2'd2, 1'b0, 2'b00, 1'b0, 2);   // c21
    push_ev(AR, 2'd2, 1'b0, 2'b00, 1'b0, 2);   // c23
    push_ev(G,  2'd3, 1'b0, 2'b10, 1'b0, 1);   // c24
    push_ev(Y,  2'd3, 1'b0, 2'b00, 1'b0, 2);   // c26
    push_ev(AR, 2'd3, 1'b0, 2'b00, 1'b0, 2);   // c28
    push_ev(G,  2'd1, 1'b0, 2'b00, 1'b0, 1);   // c29
    push_ev(Y,  2'd1, 1'b0, 2'b00, 1'b0, 3);   // c32
    push_ev(AR, 2'd1, 1'b0, 2'b00, 1'b1, 2);   // c34
    push_ev(G,  2'd0, 1'b0, 2'b00, 1'b0, 1);   // c35
    // tick every 3rd cycle (c38..c53): dwells stretch x3.
    push_ev(Y,  2'd0, 1'b0, 2'b00, 1'b0, 9);   // c44
    push_ev(AR, 2'd0, 1'b0, 2'b00, 1'b0, 6);   // c50
    push_ev(G,  2'd1, 1'b0, 2'b00, 1'b0, 3);   // c53
    push_ev(Y,  2'd1, 1'b0, 2'b00, 1'b0, 3);   // c56
    push_ev(AR, 2'd1, 1'b0, 2'b00, 1'b1, 2);   // c58
    push_ev(G,  2'd0, 1'b0, 2'b00, 1'b0, 1);   // c59
    // maintenance c60..c66 mid-green; flash toggles every 2 cycles.
    push_ev(M,  2'd0, 1'b1, 2'b00, 1'b0, 1);   // c60
    push_ev(M,  2'd0, 1'b0, 2'b00, 1'b0, 2);   // c62
    push_ev(M,  2'd0, 1'b1, 2'b00, 1'b0, 2);   // c64
    push_ev(M,  2'd0, 1'b0, 2'b00, 1'b0, 2);   // c66
    push_ev(AR, 2'd0, 1'b0, 2'b00, 1'b0, 1);   // c67
    push_ev(G,  2'd0, 1'b0, 2'b00, 1'b0, 1);   // c68
    // rst in yellow with pending=01: pending cleared, phase 0 served.
    push_ev(Y,  2'd0, 1'b0, 2'b00, 1'b0, 3);   // c71
    push_ev(AR, 2'd0, 1'b0, 2'b00, 1'b0, 1);   // c72
    push_ev(G,  2'd0, 1'b0, 2'b00, 1'b0, 2);   // c74
    push_ev(Y,  2'd0, 1'b0, 2'b00, 1'b0, 3);   // c77
    push_ev(AR, 2'd0, 1'b0, 2'b00, 1'b0, 2);   // c79
    push_ev(G,  2'd1, 1'b0, 2'b00, 1'b0, 1);   // c80
    // prio_req[0] held c81..c90: ch2 served twice in a row.
    push_ev(Y,  2'd1, 1'b0, 2'b00, 1'b0, 3);   // c83
    push_ev(AR, 2'd1, 1'b0, 2'b00, 1'b1, 2);   // c85
    push_ev(G,  2'd2, 1'b0, 2'b01, 1'b0, 1);   // c86
    push_ev(Y,  2'd2, 1'b0, 2'b00, 1'b0, 2);   // c88
    push_ev(AR, 2'd2, 1'b0, 2'b00, 1'b0, 2);   // c90
    push_ev(G,  2'd2, 1'b0, 2'b01, 1'b0, 1);   // c91
    push_ev(Y,  2'd2, 1'b0, 2'b00, 1'b0, 2);   // c93
    push_ev(AR, 2'd2, 1'b0, 2'b00, 1'b0, 2);   // c95
    push_ev(G,  2'd0, 1'b0, 2'b00, 1'b0, 1);   // c96
    push_ev(Y,  2'd0, 1'b0, 2'b00, 1'b0, 3);   // c99

    armed = 1'b1;

    // Inputs set here are sampled at rising edge number c.
    for (int c = 1; c <= 100; c++) begin
      rst         = (c == 72 || c == 73);
      tick        = (c >= 36 && c <= 53) ? (c % 3 == 2) : 1'b1;
      maintenance = (c >= 60 && c <= 66);
      if (c == 14) begin
        prio_req = 2'b11;
      end else if (c == 71 || (c >= 81 && c <= 90)) begin
        prio_req = 2'b01;
      end else begin
        prio_req = 2'b00;
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
